// File: rtl/lock_pkg.sv
// Shared definitions for the keypad lock controller.
// Holds the controller state encoding, the default parameter values and the
// checker-response timeout used by the top level and the timer.
package lock_pkg;

    typedef enum logic [2:0] {
        SETUP   = 3'd0,
        LOCKED  = 3'd1,
        ENTRY   = 3'd2,
        CHECK   = 3'd3,
        OPEN    = 3'd4,
        LOCKOUT = 3'd5
    } lock_state_t;

    localparam int DEF_MAX_DIGITS       = 4;
    localparam int DEF_MAX_ATTEMPTS     = 3;
    localparam int DEF_UNLOCK_CYCLES    = 500;
    localparam int DEF_LOCKOUT_CYCLES   = 1000;
    // Cycles the checker gets after the compare pulse before silence counts as a mismatch
    localparam int CHECK_TIMEOUT_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter with a zero flag, shared by the OPEN hold time, the
// LOCKOUT hold time and the CHECK response timeout.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   load         load load_value this cycle (wins over enable)
//   load_value   start value
//   enable       count down by one per cycle while non-zero
//   done         count has reached zero
module lock_timer
    import lock_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    output logic             done
);

    logic [WIDTH-1:0] count_r;

    // Count register: load has priority, otherwise decrement toward zero and hold there
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (enable && (count_r != '0)) begin
            count_r <= count_r - WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign done = (count_r == '0);

endmodule

// File: rtl/lock_controller.sv
// Keypad lock controller: programs a code into an external checker, collects
// user entries, starts compares and reacts to the checker verdict with an
// open period or a lockout after repeated failures.
// Ports:
//   clk, system_reset          clock, asynchronous active-low reset
//   key_valid, key_code        digit strobe and digit value
//   key_enter                  entry-complete strobe
//   correct_password,
//   incorrect_password         checker verdict
//   input_value, store_value   one-cycle writes of digit_out into the checker
//   compare                    one-cycle compare start
//   input_reset                active-low one-cycle clear of the checker input
//   digit_out                  digit presented to the checker
//   unlocked, locked_out       lock open / lockout indicators
module lock_controller
    import lock_pkg::*;
#(
    parameter int MAX_DIGITS     = DEF_MAX_DIGITS,
    parameter int MAX_ATTEMPTS   = DEF_MAX_ATTEMPTS,
    parameter int UNLOCK_CYCLES  = DEF_UNLOCK_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic       clk,
    input  logic       system_reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       key_enter,
    input  logic       correct_password,
    input  logic       incorrect_password,
    output logic       input_value,
    output logic       store_value,
    output logic       compare,
    output logic       input_reset,
    output logic [3:0] digit_out,
    output logic       unlocked,
    output logic       locked_out
);

    localparam int TW = $clog2(max_int(max_int(UNLOCK_CYCLES, LOCKOUT_CYCLES),
                                       CHECK_TIMEOUT_CYCLES) + 1);
    localparam int DW = $clog2(MAX_DIGITS + 1);
    localparam int AW = $clog2(MAX_ATTEMPTS + 1);

    // A load of N-1 keeps the state for exactly N cycles (the zero cycle included)
    localparam logic [TW-1:0] OPEN_LOAD    = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(CHECK_TIMEOUT_CYCLES);
    localparam logic [DW-1:0] DIGITS_MAX   = DW'(MAX_DIGITS);
    localparam logic [AW-1:0] ATTEMPT_LAST = AW'(MAX_ATTEMPTS - 1);

    lock_state_t   state_r, state_s;
    logic [DW-1:0] digit_count_r, digit_count_s;
    logic [AW-1:0] attempts_r, attempts_s;
    logic [3:0]    digit_out_r, digit_s;
    logic          input_value_r, input_value_s;
    logic          store_value_r, store_value_s;
    logic          compare_r, compare_s;
    logic          input_reset_r, input_reset_s;
    logic          unlocked_r, locked_out_r;
    logic          timer_load_s;
    logic [TW-1:0] timer_value_s;
    logic          timer_enable_s;
    logic          timer_done_s;
    logic          enter_s;

    // A digit strobe in the same cycle swallows the enter strobe
    assign enter_s        = key_enter & ~key_valid;
    assign timer_enable_s = (state_r == CHECK) || (state_r == OPEN) || (state_r == LOCKOUT);

    lock_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (system_reset),
        .load       (timer_load_s),
        .load_value (timer_value_s),
        .enable     (timer_enable_s),
        .done       (timer_done_s)
    );

    // Next-state and next-output decode
    always_comb begin
        state_s       = state_r;
        digit_count_s = digit_count_r;
        attempts_s    = attempts_r;
        digit_s       = digit_out_r;
        input_value_s = 1'b0;
        store_value_s = 1'b0;
        compare_s     = 1'b0;
        input_reset_s = 1'b1;
        timer_load_s  = 1'b0;
        timer_value_s = '0;
        case (state_r)
            SETUP: begin
                if (key_valid) begin
                    if (digit_count_r < DIGITS_MAX) begin
                        digit_s       = key_code;
                        store_value_s = 1'b1;
                        digit_count_s = digit_count_r + DW'(1);
                    end else begin
                        digit_count_s = digit_count_r;
                    end
                end else if (enter_s) begin
                    if (digit_count_r != '0) begin
                        state_s       = LOCKED;
                        digit_count_s = '0;
                    end else begin
                        state_s = SETUP;
                    end
                end else begin
                    state_s = SETUP;
                end
            end
            LOCKED: begin
                if (key_valid) begin
                    digit_s       = key_code;
                    input_value_s = 1'b1;
                    digit_count_s = DW'(1);
                    state_s       = ENTRY;
                end else begin
                    state_s = LOCKED;
                end
            end
            ENTRY: begin
                if (key_valid) begin
                    if (digit_count_r < DIGITS_MAX) begin
                        digit_s       = key_code;
                        input_value_s = 1'b1;
                        digit_count_s = digit_count_r + DW'(1);
                    end else begin
                        digit_count_s = digit_count_r;
                    end
                end else if (enter_s) begin
                    compare_s     = 1'b1;
                    state_s       = CHECK;
                    timer_load_s  = 1'b1;
                    timer_value_s = TIMEOUT_LOAD;
                end else begin
                    state_s = ENTRY;
                end
            end
            CHECK: begin
                if (correct_password) begin
                    attempts_s    = '0;
                    input_reset_s = 1'b0;
                    digit_count_s = '0;
                    state_s       = OPEN;
                    timer_load_s  = 1'b1;
                    timer_value_s = OPEN_LOAD;
                end else if (incorrect_password || timer_done_s) begin
                    // Checker silence until the timer drains is treated as a mismatch
                    attempts_s    = attempts_r + AW'(1);
                    input_reset_s = 1'b0;
                    digit_count_s = '0;
                    if (attempts_r >= ATTEMPT_LAST) begin
                        state_s       = LOCKOUT;
                        timer_load_s  = 1'b1;
                        timer_value_s = LOCKOUT_LOAD;
                    end else begin
                        state_s = LOCKED;
                    end
                end else begin
                    state_s = CHECK;
                end
            end
            OPEN: begin
                if (enter_s || timer_done_s) begin
                    state_s = LOCKED;
                end else begin
                    state_s = OPEN;
                end
            end
            LOCKOUT: begin
                if (timer_done_s) begin
                    attempts_s = '0;
                    state_s    = LOCKED;
                end else begin
                    state_s = LOCKOUT;
                end
            end
            default: begin
                state_s       = SETUP;
                digit_count_s = '0;
                attempts_s    = '0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge system_reset) begin
        if (!system_reset) begin
            state_r       <= SETUP;
            digit_count_r <= '0;
            attempts_r    <= '0;
            digit_out_r   <= 4'd0;
            input_value_r <= 1'b0;
            store_value_r <= 1'b0;
            compare_r     <= 1'b0;
            input_reset_r <= 1'b1;
            unlocked_r    <= 1'b0;
            locked_out_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            digit_count_r <= digit_count_s;
            attempts_r    <= attempts_s;
            digit_out_r   <= digit_s;
            input_value_r <= input_value_s;
            store_value_r <= store_value_s;
            compare_r     <= compare_s;
            input_reset_r <= input_reset_s;
            unlocked_r    <= (state_s == OPEN);
            locked_out_r  <= (state_s == LOCKOUT);
        end
    end

    assign input_value = input_value_r;
    assign store_value = store_value_r;
    assign compare     = compare_r;
    assign input_reset = input_reset_r;
    assign digit_out   = digit_out_r;
    assign unlocked    = unlocked_r;
    assign locked_out  = locked_out_r;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus tasks update an abstract
// model of the lock and queue the checker-facing events it should cause; an
// independent monitor turns DUT outputs into events and compares in order.
module tb_lock_controller;

    localparam int MAX_DIGITS     = 4;
    localparam int MAX_ATTEMPTS   = 3;
    localparam int UNLOCK_CYCLES  = 500;
    localparam int LOCKOUT_CYCLES = 1000;
    // Compare cycle plus four silent cycles, then the registered input_reset
    localparam int TIMEOUT_DELAY  = 5;

    localparam int EV_STORE = 0, EV_INPUT = 1, EV_COMPARE = 2, EV_IRST = 3, EV_OPEN = 4, EV_LOCKOUT = 5;
    localparam int M_SETUP = 0, M_LOCKED = 1, M_ENTRY = 2, M_CHECK = 3, M_OPEN = 4, M_LOCKOUT = 5;
    localparam int K_CORRECT = 0, K_INCORRECT = 1, K_TIMEOUT = 2;

    typedef struct {
        int kind;
        int val;
    } ev_t;

    logic       clk;
    logic       system_reset;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_enter;
    logic       correct_password;
    logic       incorrect_password;
    logic       input_value;
    logic       store_value;
    logic       compare;
    logic       input_reset;
    logic [3:0] digit_out;
    logic       unlocked;
    logic       locked_out;

    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  cmp_cyc  = 0;
    int  open_run = 0;
    int  lock_run = 0;

    int  mode, nstored, ndig, attempts, enter_cyc, open_start, lock_start;

    lock_controller #(
        .MAX_DIGITS     (MAX_DIGITS),
        .MAX_ATTEMPTS   (MAX_ATTEMPTS),
        .UNLOCK_CYCLES  (UNLOCK_CYCLES),
        .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
    ) dut (
        .clk                (clk),
        .system_reset       (system_reset),
        .key_valid          (key_valid),
        .key_code           (key_code),
        .key_enter          (key_enter),
        .correct_password   (correct_password),
        .incorrect_password (incorrect_password),
        .input_value        (input_value),
        .store_value        (store_value),
        .compare            (compare),
        .input_reset        (input_reset),
        .digit_out          (digit_out),
        .unlocked           (unlocked),
        .locked_out         (locked_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_STORE:   return "STORE";
            EV_INPUT:   return "INPUT";
            EV_COMPARE: return "COMPARE";
            EV_IRST:    return "IRST";
            EV_OPEN:    return "OPEN";
            EV_LOCKOUT: return "LOCKOUT";
            default:    return "?";
        endcase
    endfunction

    task automatic push(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input int val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL event @%0d: got %s val=%0d, expected no event", cyc, ev_name(kind), val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val) begin
                failures++;
                $display("FAIL event @%0d: got %s val=%0d, expected %s val=%0d",
                         cyc, ev_name(kind), val, ev_name(e.kind), e.val);
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Monitor: converts DUT outputs into events; lengths of unlocked/locked_out runs reported on their fall
    initial begin
        forever begin
            @(negedge clk);
            if (!system_reset) begin
                open_run = 0;
                lock_run = 0;
            end else begin
                if (store_value || input_value || compare) begin
                    chk("onehot_pulses", int'($onehot0({store_value, input_value, compare})), 1);
                end
                if (store_value) observe(EV_STORE, int'(digit_out));
                if (input_value) observe(EV_INPUT, int'(digit_out));
                if (compare) begin
                    observe(EV_COMPARE, 0);
                    cmp_cyc = cyc;
                end
                if (!input_reset) observe(EV_IRST, cyc - cmp_cyc);
                if (unlocked) begin
                    open_run++;
                end else if (open_run > 0) begin
                    observe(EV_OPEN, open_run);
                    open_run = 0;
                end
                if (locked_out) begin
                    lock_run++;
                end else if (lock_run > 0) begin
                    observe(EV_LOCKOUT, lock_run);
                    lock_run = 0;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic model_reset();
        mode     = M_SETUP;
        nstored  = 0;
        ndig     = 0;
        attempts = 0;
    endtask

    task automatic model_key(input int d);
        case (mode)
            M_SETUP:  if (nstored < MAX_DIGITS) begin push(EV_STORE, d); nstored++; end
            M_LOCKED: begin push(EV_INPUT, d); ndig = 1; mode = M_ENTRY; end
            M_ENTRY:  if (ndig < MAX_DIGITS) begin push(EV_INPUT, d); ndig++; end
            default:  ;
        endcase
    endtask

    task automatic model_enter();
        case (mode)
            M_SETUP: if (nstored > 0) mode = M_LOCKED;
            M_ENTRY: begin push(EV_COMPARE, 0); mode = M_CHECK; enter_cyc = cyc; end
            M_OPEN:  begin push(EV_OPEN, cyc - open_start); mode = M_LOCKED; end
            default: ;
        endcase
    endtask

    task automatic press(input int d, input int gap);
        key_valid = 1'b1;
        key_code  = 4'(d);
        model_key(d);
        tick(1);
        key_valid = 1'b0;
        tick(gap);
    endtask

    task automatic enter_key(input int gap);
        key_enter = 1'b1;
        model_enter();
        tick(1);
        key_enter = 1'b0;
        tick(gap);
    endtask

    task automatic press_both(input int d, input int gap);
        key_valid = 1'b1;
        key_enter = 1'b1;
        key_code  = 4'(d);
        model_key(d);
        tick(1);
        key_valid = 1'b0;
        key_enter = 1'b0;
        tick(gap);
    endtask

    // Checker answer r cycles after the compare pulse (or none at all)
    task automatic respond(input int kind, input int r);
        int delay;
        if (kind == K_TIMEOUT) begin
            delay = TIMEOUT_DELAY;
            push(EV_IRST, delay);
            tick(TIMEOUT_DELAY + 3);
        end else begin
            tick(r);
            delay = cyc - enter_cyc;
            push(EV_IRST, delay);
            if (kind == K_CORRECT) correct_password = 1'b1;
            else incorrect_password = 1'b1;
            tick(1);
            correct_password   = 1'b0;
            incorrect_password = 1'b0;
            tick(2);
        end
        if (kind == K_CORRECT) begin
            attempts   = 0;
            mode       = M_OPEN;
            open_start = enter_cyc + delay;
        end else begin
            attempts++;
            if (attempts >= MAX_ATTEMPTS) begin
                mode       = M_LOCKOUT;
                lock_start = enter_cyc + delay;
            end else begin
                mode = M_LOCKED;
            end
        end
    endtask

    task automatic entry(input int n, input int kind, input int r);
        for (int i = 0; i < n; i++) press($urandom_range(0, 15), $urandom_range(1, 2));
        enter_key(0);
        respond(kind, r);
    endtask

    task automatic open_expire();
        push(EV_OPEN, UNLOCK_CYCLES);
        tick_until(open_start + UNLOCK_CYCLES + 3);
        mode = M_LOCKED;
    endtask

    task automatic open_relock(input int wait_cycles);
        tick(wait_cycles);
        enter_key(2);
    endtask

    task automatic lockout_wait();
        push(EV_LOCKOUT, LOCKOUT_CYCLES);
        while (cyc < lock_start + LOCKOUT_CYCLES - 20) begin
            if ($urandom_range(0, 1) == 1) press($urandom_range(0, 15), $urandom_range(50, 200));
            else enter_key($urandom_range(50, 200));
        end
        tick_until(lock_start + LOCKOUT_CYCLES + 3);
        attempts = 0;
        mode     = M_LOCKED;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_input_value"}, int'(input_value), 0);
        chk({tag, "_store_value"}, int'(store_value), 0);
        chk({tag, "_compare"},     int'(compare),     0);
        chk({tag, "_input_reset"}, int'(input_reset), 1);
        chk({tag, "_digit_out"},   int'(digit_out),   0);
        chk({tag, "_unlocked"},    int'(unlocked),    0);
        chk({tag, "_locked_out"},  int'(locked_out),  0);
    endtask

    // Assert reset mid-cycle; outputs must change without waiting for a clock edge
    task automatic reset_mid(input string tag);
        @(posedge clk);
        #2;
        system_reset = 1'b0;
        #1;
        check_reset_outputs(tag);
        chk({tag, "_queue_drained"}, exp_q.size(), 0);
        @(negedge clk);
        tick(1);
        system_reset = 1'b1;
        model_reset();
        tick(2);
    endtask

    initial begin
        int kind;
        system_reset       = 1'b1;
        key_valid          = 1'b0;
        key_code           = 4'd0;
        key_enter          = 1'b0;
        correct_password   = 1'b0;
        incorrect_password = 1'b0;
        model_reset();
        #1;
        system_reset = 1'b0;
        tick(2);
        check_reset_outputs("reset");
        system_reset = 1'b1;
        tick(2);

        // Setup 1,2,3 (an empty enter first must be ignored), then the right code
        enter_key(2);
        press(1, 1); press(2, 1); press(3, 1);
        enter_key(2);
        press(1, 1); press(2, 1); press(3, 1);
        enter_key(0);
        respond(K_CORRECT, 1);
        press(7, 3);
        open_expire();

        // Three wrong entries lead to lockout, keys ignored throughout
        for (int i = 0; i < MAX_ATTEMPTS; i++) entry($urandom_range(1, 4), K_INCORRECT, $urandom_range(0, 3));
        lockout_wait();

        // Six digits give four writes; early relock with enter
        entry(6, K_CORRECT, 0);
        open_relock(40);

        // Simultaneous digit and enter: digit only; then checker silence
        press_both(5, 1);
        press_both(6, 1);
        enter_key(0);
        respond(K_TIMEOUT, 0);
        entry(2, K_INCORRECT, 2);
        entry(1, K_INCORRECT, 3);
        lockout_wait();

        // Randomized sessions
        for (int i = 0; i < 5; i++) begin
            kind = $urandom_range(0, 2);
            entry($urandom_range(1, 6), kind, $urandom_range(0, 3));
            if (mode == M_OPEN) begin
                if ($urandom_range(0, 1) == 1) open_expire();
                else open_relock($urandom_range(5, 300));
            end else if (mode == M_LOCKOUT) begin
                lockout_wait();
            end
        end

        // Reset while open, then while locked out
        entry(3, K_CORRECT, 1);
        tick(20);
        reset_mid("rst_open");
        for (int i = 0; i < 6; i++) press($urandom_range(0, 15), 1);
        enter_key(2);
        for (int i = 0; i < MAX_ATTEMPTS; i++) entry(2, K_INCORRECT, 1);
        tick(50);
        reset_mid("rst_lockout");
        // Back in SETUP: a digit must be stored, not entered
        press(9, 2);
        tick(5);
        chk("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 4, the maximum number of code digits per entry.
REQ-002 SHALL have parameter MAX_ATTEMPTS, default 3, the number of consecutive failed compares that triggers lockout.
REQ-003 SHALL have parameter UNLOCK_CYCLES, default 500, the number of cycles the lock stays open.
REQ-004 SHALL have parameter LOCKOUT_CYCLES, default 1000, the number of cycles keys are ignored after lockout.
REQ-005 SHALL have port clk, input, 1 bit, the single system clock with all logic on its rising edge.
REQ-006 SHALL have port system_reset, input, 1 bit, the reset, which is asynchronous and active-low.
REQ-007 SHALL have port key_valid, input, 1 bit, a one-cycle strobe meaning key_code holds a digit.
REQ-008 SHALL have port key_code, input, 4 bits, the keypad digit.
REQ-009 SHALL have port key_enter, input, 1 bit, a one-cycle strobe meaning the entry is complete.
REQ-010 SHALL have port correct_password, input, 1 bit, the checker "match" result.
REQ-011 SHALL have port incorrect_password, input, 1 bit, the checker "mismatch" result.
REQ-012 SHALL have port input_value, output, 1 bit, a one-cycle pulse that stores digit_out into the checker input register.
REQ-013 SHALL have port store_value, output, 1 bit, a one-cycle pulse that stores digit_out into the checker system register.
REQ-014 SHALL have port compare, output, 1 bit, a one-cycle pulse that starts a checker compare.
REQ-015 SHALL have port input_reset, output, 1 bit, active-low, a one-cycle low that clears the checker input register.
REQ-016 SHALL have port digit_out, output, 4 bits, the digit presented to the checker.
REQ-017 SHALL have port unlocked, output, 1 bit, high while the lock is open.
REQ-018 SHALL have port locked_out, output, 1 bit, high during lockout.

Function
REQ-019 SHALL implement the states SETUP, LOCKED, ENTRY, CHECK, OPEN and LOCKOUT, and SHALL enter SETUP from reset.
REQ-020 SHALL register key_code into digit_out on an accepted key_valid, then pulse input_value or store_value in the next cycle with digit_out stable; latency is 1 cycle.
REQ-021 In SETUP, SHALL store each accepted digit with store_value, up to MAX_DIGITS digits, with further digits ignored.
REQ-022 In SETUP, key_enter with at least one digit stored SHALL go to LOCKED; key_enter with zero digits SHALL be ignored.
REQ-023 In LOCKED, the first key_valid SHALL pulse input_value, set digit_count to 1 and go to ENTRY.
REQ-024 In ENTRY, key_valid SHALL pulse input_value and increment digit_count while digit_count < MAX_DIGITS, and SHALL be ignored otherwise.
REQ-025 In ENTRY, key_enter SHALL pulse compare in the next cycle and go to CHECK.
REQ-026 When key_valid and key_enter arrive in the same cycle, key_valid SHALL win and key_enter SHALL be dropped.
REQ-027 In CHECK, correct_password SHALL clear the attempt counter, drive input_reset low for 1 cycle and go to OPEN.
REQ-028 In CHECK, incorrect_password SHALL increment the attempt counter and drive input_reset low for 1 cycle.
REQ-029 After incorrect_password, the FSM SHALL go to LOCKOUT if the counter reaches MAX_ATTEMPTS, else to LOCKED.
REQ-030 In CHECK, if neither result arrives within 4 cycles of the compare pulse, the timeout SHALL be handled as incorrect_password.
REQ-031 In OPEN, unlocked SHALL be 1 for UNLOCK_CYCLES cycles, then the FSM SHALL go to LOCKED; key_enter SHALL relock immediately.
REQ-032 In LOCKOUT, locked_out SHALL be 1 and all keys ignored for LOCKOUT_CYCLES cycles, then the attempt counter SHALL clear and the FSM SHALL go to LOCKED.
REQ-033 Keys SHALL be ignored in CHECK and LOCKOUT, and in OPEN except key_enter.
REQ-034 At most one of input_value, store_value and compare SHALL be high in any cycle.

Reset
REQ-035 Reset SHALL be asynchronous on the fall of system_reset, and release SHALL be synchronous to clk.
REQ-036 During reset the values SHALL be: state SETUP; input_value, store_value, compare, unlocked and locked_out 0; input_reset 1; digit_out 0; all counters and timers 0.
REQ-037 Reset asserted mid-operation, in any state, SHALL abort immediately to these values.

Structure
REQ-038 A shared package lock_pkg SHALL hold the state enum and the default parameter constants.
REQ-039 A sub-module lock_timer SHALL implement a loadable down-counter with a done flag, shared by the OPEN timer, the LOCKOUT timer and the CHECK timeout.

Verification
REQ-040 Scenario 1: reset, setup 1,2,3 then enter, enter 1,2,3 then enter, checker returns correct -> three store_value pulses, three input_value pulses, one compare, then unlocked=1 for 500 cycles and back to LOCKED.
REQ-041 Scenario 2: three wrong entries, each with incorrect_password -> input_reset low once per attempt, then locked_out=1 for 1000 cycles with key_valid ignored, then LOCKED.
REQ-042 Scenario 3: enter 6 digits -> exactly 4 input_value pulses.
REQ-043 Scenario 4: key_valid and key_enter in the same cycle -> one input_value pulse, no compare.
REQ-044 Scenario 5: no checker response after compare -> after 4 cycles, attempt counter increments and FSM goes to LOCKED.
REQ-045 Scenario 6: system_reset asserted in OPEN and in LOCKOUT -> outputs take reset values within the same cycle, and the FSM is in SETUP.
